dcache_2way_top: RTL
====================

Name: dcache_2way_top

Overview:
- Two-way set-associative, write-back, write-allocate data cache between the CPU data port and the 256-bit-line data memory.
- Parametrised successor of the direct-mapped dcache: set count and line width are generalised, and it adds per-set LRU replacement and dirty-victim selection across ways.
- Tag, valid, dirty, LRU and data storage are internal flop arrays with asynchronous read, so no external SRAM macros are needed.

Parameters:
- INDEX_W, 5, set-index bits; sets = 2**INDEX_W.
- LINE_W, 256, line width in bits; power of two, 64 or more.
- Derived, not overridable:
  - OFFSET_W = log2(LINE_W/8).
  - TAG_W = 32 - INDEX_W - OFFSET_W.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- mem_data_i  in  LINE_W  refill line from memory.
- mem_ack_i  in  1  one-cycle completion pulse from memory.
- mem_data_o  out  LINE_W  write-back line (victim data).
- mem_addr_o  out  32  line address; low OFFSET_W bits always 0.
- mem_enable_o  out  1  memory request; held until ack.
- mem_write_o  out  1  1 = write-back, 0 = refill read.
- p1_data_i  in  32  CPU store data.
- p1_addr_i  in  32  CPU byte address.
- p1_MemRead_i  in  1  load request.
- p1_MemWrite_i  in  1  store request.
- p1_data_o  out  32  load data.
- p1_stall_o  out  1  CPU stall.

Behaviour:
- Address split:
  - tag = addr[31:INDEX_W+OFFSET_W]
  - index = addr[INDEX_W+OFFSET_W-1:OFFSET_W]
  - word = addr[OFFSET_W-1:2]; addr[1:0] ignored.
- req = MemRead | MemWrite. Way w hits when valid[w][index] and tag[w][index] == tag; both ways hitting cannot occur.
- p1_stall_o = req & ~hit, combinational. No stall when req = 0.
- Read hit: p1_data_o = selected 32-bit word of the hit way, combinational, zero latency. p1_data_o = 0 when there is no hit.
- Write hit, on the clock edge:
  - selected word replaced by p1_data_i; other words unchanged.
  - dirty[hitway][index] = 1.
- LRU: one bit per set naming the victim way. Any hit (read or write) and any refill set it to the other way.
- Reset (async, active-low):
  - state = IDLE.
  - mem_enable_o, mem_write_o = 0.
  - all valid, dirty and LRU bits = 0.
  - data and tag arrays are not reset.
- A reset during a memory transaction abandons it immediately; the memory must tolerate enable dropping.
- FSM states: IDLE, MISS, WRITEBACK, REFILL, REFILLOK.
  - IDLE: req & ~hit -> MISS; latch victim = LRU[index].
  - MISS:
    - victim valid & dirty -> WRITEBACK; mem_enable = 1, mem_write = 1.
    - otherwise -> REFILL; mem_enable = 1, mem_write = 0.
  - WRITEBACK: mem_addr_o = {victim tag, index, 0}; mem_data_o = victim line. On mem_ack_i: mem_write = 0, enable stays 1 -> REFILL.
  - REFILL: mem_addr_o = {p1 tag, index, 0}. On mem_ack_i, same edge:
    - mem_enable = 0.
    - victim line <= mem_data_i; tag written; valid = 1; dirty = 0; LRU = other way.
    - -> REFILLOK.
  - REFILLOK: -> IDLE. Next cycle the request hits; a pending store then writes as a write hit.
- mem_enable_o and mem_write_o are registered outputs. mem_addr_o and mem_data_o are decoded from state, latched victim and current index.
- The CPU holds addr, data and req stable while stalled. If req drops mid-miss, the refill still completes and the line is installed.
- mem_ack_i is ignored in IDLE, MISS and REFILLOK.
- Hit cycles do not block: the FSM stays in IDLE.

Optional Feature:
- Macro DCACHE_STATS_EN.
- Defined: adds outputs acc_cnt_o, miss_cnt_o, wb_cnt_o, 32 bits each, reset to 0, wrapping at 2**32.
  - acc_cnt_o increments each IDLE cycle with req & hit.
  - miss_cnt_o increments on IDLE->MISS.
  - wb_cnt_o increments on MISS->WRITEBACK.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset, then load 0x0000_0404 -> stall; REFILL with mem_addr_o = 0x0000_0400, mem_write_o = 0. After ack + 2 cycles, stall = 0 and p1_data_o = word 1 of the supplied line.
- Store 0xDEADBEEF to 0x400, then load 0x400 -> no stall on the load; p1_data_o = 0xDEADBEEF; dirty set.
- Loads 0x0400, 0x2400, 0x0400 (same set, INDEX_W = 5) -> both lines resident; third load hits; LRU points to the 0x2400 way.
- Dirty 0x0400, touch 0x2400, then load 0x4400 -> WRITEBACK with mem_addr_o = 0x0400 carrying the 0xDEADBEEF line, then REFILL 0x4400; 0x2400 still hits.
- Assert rst_i = 0 mid-WRITEBACK -> mem_enable_o = 0 at once; every earlier address misses after release.
- With DCACHE_STATS_EN, run the sequence above -> counts match the expected values (e.g. wb_cnt_o = 1).

Source files
------------

// File: rtl/dcache_2way_top.sv
// rtl/dcache_2way_top.sv - two-way set-associative write-back/write-allocate data cache
// Optional access/miss/write-back counters enabled by defining DCACHE_STATS_EN.
module dcache_2way_top #(
    parameter int INDEX_W = 5,
    parameter int LINE_W  = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [LINE_W-1:0] mem_data_o,
    output logic [31:0]       mem_addr_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    input  logic [31:0]       p1_data_i,
    input  logic [31:0]       p1_addr_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    output logic [31:0]       p1_data_o,
    output logic              p1_stall_o
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       acc_cnt_o,
    output logic [31:0]       miss_cnt_o,
    output logic [31:0]       wb_cnt_o
`endif
);
    localparam int OFFSET_W = $clog2(LINE_W / 8);
    localparam int TAG_W    = 32 - INDEX_W - OFFSET_W;
    localparam int SETS     = 2 ** INDEX_W;
    localparam int WSEL_W   = OFFSET_W - 2;

    typedef enum logic [2:0] {IDLE, MISS, WRITEBACK, REFILL, REFILLOK} state_t;
    state_t state_q, state_d;

    logic [TAG_W-1:0]  tag_q   [2][SETS];
    logic [LINE_W-1:0] data_q  [2][SETS];
    logic [SETS-1:0]   valid_q [2];
    logic [SETS-1:0]   dirty_q [2];
    logic [SETS-1:0]   lru_q;

    logic               mem_enable_q, mem_write_q, en_d, wr_d, refill_we;
    logic               victim_q;
    logic [TAG_W-1:0]   miss_tag_q;
    logic [INDEX_W-1:0] miss_index_q;

    logic [TAG_W-1:0]   p1_tag;
    logic [INDEX_W-1:0] p1_index;
    logic [WSEL_W-1:0]  p1_word;
    logic [WSEL_W+4:0]  bit_lo;
    logic               unused_byte_sel;
    logic               req, hit0, hit1, hit, hit_way;
    logic [LINE_W-1:0]  hit_line;

    assign p1_tag          = p1_addr_i[31 -: TAG_W];
    assign p1_index        = p1_addr_i[OFFSET_W +: INDEX_W];
    assign p1_word         = p1_addr_i[2 +: WSEL_W];
    assign bit_lo          = {p1_word, 5'd0};
    assign unused_byte_sel = ^p1_addr_i[1:0];

    assign req     = p1_MemRead_i | p1_MemWrite_i;
    assign hit0    = valid_q[0][p1_index] && (tag_q[0][p1_index] == p1_tag);
    assign hit1    = valid_q[1][p1_index] && (tag_q[1][p1_index] == p1_tag);
    assign hit     = hit0 | hit1;
    assign hit_way = hit1;

    assign hit_line   = hit_way ? data_q[1][p1_index] : data_q[0][p1_index];
    assign p1_data_o  = hit ? hit_line[bit_lo +: 32] : 32'd0;
    assign p1_stall_o = req & ~hit;

    // Miss address is latched so a CPU that drops its request mid-miss still gets a coherent refill.
    assign mem_addr_o   = (state_q == WRITEBACK)
                        ? {tag_q[victim_q][miss_index_q], miss_index_q, {OFFSET_W{1'b0}}}
                        : {miss_tag_q, miss_index_q, {OFFSET_W{1'b0}}};
    assign mem_data_o   = data_q[victim_q][miss_index_q];
    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;

    always_comb begin
        state_d   = state_q;
        en_d      = mem_enable_q;
        wr_d      = mem_write_q;
        refill_we = 1'b0;
        case (state_q)
            IDLE: if (req && !hit) state_d = MISS;
            MISS: begin
                en_d = 1'b1;
                if (valid_q[victim_q][miss_index_q] && dirty_q[victim_q][miss_index_q]) begin
                    state_d = WRITEBACK;
                    wr_d    = 1'b1;
                end else begin
                    state_d = REFILL;
                    wr_d    = 1'b0;
                end
            end
            WRITEBACK: if (mem_ack_i) begin
                state_d = REFILL;
                wr_d    = 1'b0;
            end
            REFILL: if (mem_ack_i) begin
                state_d   = REFILLOK;
                en_d      = 1'b0;
                refill_we = 1'b1;
            end
            REFILLOK: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            victim_q     <= 1'b0;
            miss_tag_q   <= '0;
            miss_index_q <= '0;
        end else begin
            state_q      <= state_d;
            mem_enable_q <= en_d;
            mem_write_q  <= wr_d;
            if (state_q == IDLE && req && !hit) begin
                victim_q     <= lru_q[p1_index];
                miss_tag_q   <= p1_tag;
                miss_index_q <= p1_index;
            end
        end
    end

    // LRU holds the way to evict next: flip it away from whatever was just used or installed.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q[0] <= '0;
            valid_q[1] <= '0;
            dirty_q[0] <= '0;
            dirty_q[1] <= '0;
            lru_q      <= '0;
        end else begin
            if (req && hit) begin
                lru_q[p1_index] <= ~hit_way;
                if (p1_MemWrite_i) dirty_q[hit_way][p1_index] <= 1'b1;
            end
            if (refill_we) begin
                valid_q[victim_q][miss_index_q] <= 1'b1;
                dirty_q[victim_q][miss_index_q] <= 1'b0;
                lru_q[miss_index_q]             <= ~victim_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (req && hit && p1_MemWrite_i) data_q[hit_way][p1_index][bit_lo +: 32] <= p1_data_i;
        if (refill_we) begin
            data_q[victim_q][miss_index_q] <= mem_data_i;
            tag_q[victim_q][miss_index_q]  <= miss_tag_q;
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            acc_cnt_o  <= '0;
            miss_cnt_o <= '0;
            wb_cnt_o   <= '0;
        end else begin
            if (state_q == IDLE && req && hit)  acc_cnt_o  <= acc_cnt_o + 32'd1;
            if (state_q == IDLE && req && !hit) miss_cnt_o <= miss_cnt_o + 32'd1;
            if (state_q == MISS && state_d == WRITEBACK) wb_cnt_o <= wb_cnt_o + 32'd1;
        end
    end
`endif
endmodule
